biriscv_issue_ctrl: RTL and testbench

Single-issue slot and hazard controller that drives the issue-side interface of the E1/E2/WB pipeline controller. It accepts decoded instructions from fetch/decode into a one-entry issue slot, resolves operand hazards with E1/E2/WB bypass or bubble insertion, and serialises CSR instructions. It also injects interrupts and flushes the slot on pipeline squash or branch redirect.

---
 rtl/biriscv_issue_ctrl_pkg.sv | 25 ++
 rtl/biriscv_issue_bypass.sv | 54 +++++
 rtl/biriscv_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_biriscv_issue_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_issue_ctrl_pkg.sv
// Shared definitions for the issue slot controller: fault code width,
// the "no fault" code and the RISC-V register field positions.
package biriscv_issue_ctrl_pkg;

    localparam int EXCEPTION_W = 6;
    localparam logic [EXCEPTION_W-1:0] EXC_NONE = '0;

    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 7;

    // Decode class bits held alongside the instruction in the slot
    typedef struct packed {
        logic lsu;
        logic csr;
        logic div;
        logic mul;
        logic branch;
        logic rd_valid;
    } issue_class_t;

endpackage

// File: rtl/biriscv_issue_bypass.sv
// Per-operand hazard detection and forwarding mux.
// Youngest producer wins: E1 ALU result, then E2 result, then WB result,
// then the register file. x0 always reads as zero and never hazards.
module biriscv_issue_bypass #(
    parameter int SUPPORT_LOAD_BYPASS = 1,
    parameter int SUPPORT_MUL_BYPASS  = 1
) (
    input  logic [4:0]  idx_i,
    input  logic [31:0] rf_value_i,
    input  logic [4:0]  rd_e1_i,
    input  logic        alu_e1_i,
    input  logic [31:0] alu_result_e1_i,
    input  logic [4:0]  rd_e2_i,
    input  logic        load_e2_i,
    input  logic        mul_e2_i,
    input  logic [31:0] result_e2_i,
    input  logic [4:0]  rd_wb_i,
    input  logic [31:0] result_wb_i,
    output logic        hazard_o,
    output logic [31:0] value_o
);

    localparam logic LOAD_BYP = (SUPPORT_LOAD_BYPASS != 0);
    localparam logic MUL_BYP  = (SUPPORT_MUL_BYPASS != 0);

    logic src_nz;
    logic hit_e1;
    logic hit_e2;
    logic hit_wb;

    assign src_nz = (idx_i != 5'd0);
    assign hit_e1 = src_nz && (idx_i == rd_e1_i);
    assign hit_e2 = src_nz && (idx_i == rd_e2_i);
    assign hit_wb = src_nz && (idx_i == rd_wb_i);

    // E1 only forwards plain ALU ops; E2 loads/muls stall unless their bypass is built in
    assign hazard_o = (hit_e1 & ~alu_e1_i)
                    | (hit_e2 & load_e2_i & ~LOAD_BYP)
                    | (hit_e2 & mul_e2_i  & ~MUL_BYP);

    // Priority forwarding mux, youngest stage first
    always_comb begin
        value_o = rf_value_i;
        if (!src_nz)
            value_o = 32'd0;
        else if (hit_e1)
            value_o = alu_result_e1_i;
        else if (hit_e2)
            value_o = result_e2_i;
        else if (hit_wb)
            value_o = result_wb_i;
    end

endmodule

// File: rtl/biriscv_issue_ctrl.sv
// One-entry issue slot with operand hazard/bypass handling, CSR drain
// serialisation, interrupt injection and squash/redirect flush.
module biriscv_issue_ctrl
    import biriscv_issue_ctrl_pkg::*;
#(
    parameter int SUPPORT_LOAD_BYPASS = 1,
    parameter int SUPPORT_MUL_BYPASS  = 1,
    parameter int CSR_DRAIN_CYCLES    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   fetch_valid_i,
    output logic                   fetch_accept_o,
    input  logic [31:0]            fetch_pc_i,
    input  logic [31:0]            fetch_instr_i,
    input  logic                   fetch_lsu_i,
    input  logic                   fetch_csr_i,
    input  logic                   fetch_div_i,
    input  logic                   fetch_mul_i,
    input  logic                   fetch_branch_i,
    input  logic                   fetch_rd_valid_i,
    input  logic [EXCEPTION_W-1:0] fetch_exception_i,
    input  logic [31:0]            rf_ra_value_i,
    input  logic [31:0]            rf_rb_value_i,
    input  logic [4:0]             rd_e1_i,
    input  logic [4:0]             rd_e2_i,
    input  logic [4:0]             rd_wb_i,
    input  logic                   alu_e1_i,
    input  logic [31:0]            alu_result_e1_i,
    input  logic                   load_e2_i,
    input  logic                   mul_e2_i,
    input  logic [31:0]            result_e2_i,
    input  logic [31:0]            result_wb_i,
    input  logic                   pipe_stall_i,
    input  logic                   squash_i,
    input  logic                   redirect_i,
    input  logic                   intr_pending_i,
    output logic                   issue_valid_o,
    output logic                   issue_accept_o,
    output logic                   issue_stall_o,
    output logic                   issue_lsu_o,
    output logic                   issue_csr_o,
    output logic                   issue_div_o,
    output logic                   issue_mul_o,
    output logic                   issue_branch_o,
    output logic                   issue_rd_valid_o,
    output logic [4:0]             issue_rd_o,
    output logic [EXCEPTION_W-1:0] issue_exception_o,
    output logic                   take_interrupt_o,
    output logic [31:0]            issue_pc_o,
    output logic [31:0]            issue_opcode_o,
    output logic [31:0]            issue_operand_ra_o,
    output logic [31:0]            issue_operand_rb_o
);

    localparam logic [7:0] CSR_DRAIN = 8'(CSR_DRAIN_CYCLES);

    logic                   slot_valid_q, slot_valid_d;
    logic [31:0]            slot_pc_q,    slot_pc_d;
    logic [31:0]            slot_instr_q, slot_instr_d;
    issue_class_t           slot_class_q, slot_class_d;
    logic [EXCEPTION_W-1:0] slot_exc_q,   slot_exc_d;
    logic [7:0]             csr_cnt_q,    csr_cnt_d;

    issue_class_t fetch_class;
    logic         hazard_ra;
    logic         hazard_rb;
    logic         ignore_hazard;
    logic         csr_busy;
    logic         blocked;
    logic         fire;
    logic         fetch_accept;
    logic         slot_load;

    assign fetch_class = '{lsu:      fetch_lsu_i,
                           csr:      fetch_csr_i,
                           div:      fetch_div_i,
                           mul:      fetch_mul_i,
                           branch:   fetch_branch_i,
                           rd_valid: fetch_rd_valid_i};

    biriscv_issue_bypass #(
        .SUPPORT_LOAD_BYPASS(SUPPORT_LOAD_BYPASS),
        .SUPPORT_MUL_BYPASS (SUPPORT_MUL_BYPASS)
    ) u_bypass_ra (
        .idx_i          (slot_instr_q[RS1_HI:RS1_LO]),
        .rf_value_i     (rf_ra_value_i),
        .rd_e1_i        (rd_e1_i),
        .alu_e1_i       (alu_e1_i),
        .alu_result_e1_i(alu_result_e1_i),
        .rd_e2_i        (rd_e2_i),
        .load_e2_i      (load_e2_i),
        .mul_e2_i       (mul_e2_i),
        .result_e2_i    (result_e2_i),
        .rd_wb_i        (rd_wb_i),
        .result_wb_i    (result_wb_i),
        .hazard_o       (hazard_ra),
        .value_o        (issue_operand_ra_o)
    );

    biriscv_issue_bypass #(
        .SUPPORT_LOAD_BYPASS(SUPPORT_LOAD_BYPASS),
        .SUPPORT_MUL_BYPASS (SUPPORT_MUL_BYPASS)
    ) u_bypass_rb (
        .idx_i          (slot_instr_q[RS2_HI:RS2_LO]),
        .rf_value_i     (rf_rb_value_i),
        .rd_e1_i        (rd_e1_i),
        .alu_e1_i       (alu_e1_i),
        .alu_result_e1_i(alu_result_e1_i),
        .rd_e2_i        (rd_e2_i),
        .load_e2_i      (load_e2_i),
        .mul_e2_i       (mul_e2_i),
        .result_e2_i    (result_e2_i),
        .rd_wb_i        (rd_wb_i),
        .result_wb_i    (result_wb_i),
        .hazard_o       (hazard_rb),
        .value_o        (issue_operand_rb_o)
    );

    // Interrupts and faulting slots never read operands, so hazards don't hold them
    assign ignore_hazard = intr_pending_i | (slot_exc_q != EXC_NONE);
    assign csr_busy      = (csr_cnt_q != 8'd0);
    assign blocked       = ((hazard_ra | hazard_rb) & ~ignore_hazard) | csr_busy;
    assign fire          = slot_valid_q & ~blocked & ~pipe_stall_i & ~squash_i & ~redirect_i;
    assign fetch_accept  = ~redirect_i & ~squash_i & (~slot_valid_q | fire);
    assign slot_load     = fetch_valid_i & fetch_accept;

    // Next slot contents and CSR drain count; flush wins over everything else
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        slot_class_d = slot_class_q;
        slot_exc_d   = slot_exc_q;
        csr_cnt_d    = csr_cnt_q;
        if (squash_i || redirect_i) begin
            slot_valid_d = 1'b0;
            csr_cnt_d    = 8'd0;
        end else begin
            if (slot_load) begin
                slot_valid_d = 1'b1;
                slot_pc_d    = fetch_pc_i;
                slot_instr_d = fetch_instr_i;
                slot_class_d = fetch_class;
                slot_exc_d   = fetch_exception_i;
            end else if (fire) begin
                slot_valid_d = 1'b0;
            end
            if (fire && slot_class_q.csr)
                csr_cnt_d = CSR_DRAIN;
            else if (!pipe_stall_i && csr_busy)
                csr_cnt_d = csr_cnt_q - 8'd1;
        end
    end

    // Slot and drain counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= 1'b0;
            slot_pc_q    <= 32'd0;
            slot_instr_q <= 32'd0;
            slot_class_q <= '0;
            slot_exc_q   <= EXC_NONE;
            csr_cnt_q    <= 8'd0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            slot_class_q <= slot_class_d;
            slot_exc_q   <= slot_exc_d;
            csr_cnt_q    <= csr_cnt_d;
        end
    end

    assign fetch_accept_o    = fetch_accept;
    assign issue_valid_o     = slot_valid_q;
    assign issue_accept_o    = slot_valid_q & ~blocked;
    assign issue_stall_o     = pipe_stall_i;
    assign take_interrupt_o  = intr_pending_i & slot_valid_q & ~csr_busy;
    assign issue_lsu_o       = slot_class_q.lsu;
    assign issue_csr_o       = slot_class_q.csr;
    assign issue_div_o       = slot_class_q.div;
    assign issue_mul_o       = slot_class_q.mul;
    assign issue_branch_o    = slot_class_q.branch;
    assign issue_rd_valid_o  = slot_class_q.rd_valid;
    assign issue_rd_o        = slot_instr_q[RD_HI:RD_LO];
    assign issue_exception_o = slot_exc_q;
    assign issue_pc_o        = slot_pc_q;
    assign issue_opcode_o    = slot_instr_q;

endmodule

// File: tb/tb_biriscv_issue_ctrl.sv
// Bench for biriscv_issue_ctrl: vector table for the bypass/hazard cases,
// hand sequences for the multi-cycle behaviour, then random traffic against
// a queue-based reference model. A second instance without E2 load bypass
// covers the WB-only path.
module tb_biriscv_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc, fetch_instr;
    logic        f_lsu, f_csr, f_div, f_mul, f_br, f_rdv;
    logic [5:0]  fetch_exc;
    logic [31:0] rf_ra, rf_rb;
    logic [4:0]  rd_e1, rd_e2, rd_wb;
    logic        alu_e1, load_e2, mul_e2;
    logic [31:0] alu_res_e1, res_e2, res_wb;
    logic        stall, squash, redirect, intr;

    logic        fetch_accept, issue_valid, issue_accept, issue_stall;
    logic        i_lsu, i_csr, i_div, i_mul, i_br, i_rdv, take_int;
    logic [4:0]  issue_rd;
    logic [5:0]  issue_exc;
    logic [31:0] issue_pc, issue_op, op_ra, op_rb;

    logic        n_fetch_accept, n_issue_valid, n_issue_accept, n_issue_stall;
    logic        n_lsu, n_csr, n_div, n_mul, n_br, n_rdv, n_take_int;
    logic [4:0]  n_issue_rd;
    logic [5:0]  n_issue_exc;
    logic [31:0] n_issue_pc, n_issue_op, n_op_ra, n_op_rb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    biriscv_issue_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_valid_i(fetch_valid), .fetch_accept_o(fetch_accept),
        .fetch_pc_i(fetch_pc), .fetch_instr_i(fetch_instr),
        .fetch_lsu_i(f_lsu), .fetch_csr_i(f_csr), .fetch_div_i(f_div),
        .fetch_mul_i(f_mul), .fetch_branch_i(f_br), .fetch_rd_valid_i(f_rdv),
        .fetch_exception_i(fetch_exc),
        .rf_ra_value_i(rf_ra), .rf_rb_value_i(rf_rb),
        .rd_e1_i(rd_e1), .rd_e2_i(rd_e2), .rd_wb_i(rd_wb),
        .alu_e1_i(alu_e1), .alu_result_e1_i(alu_res_e1),
        .load_e2_i(load_e2), .mul_e2_i(mul_e2),
        .result_e2_i(res_e2), .result_wb_i(res_wb),
        .pipe_stall_i(stall), .squash_i(squash), .redirect_i(redirect),
        .intr_pending_i(intr),
        .issue_valid_o(issue_valid), .issue_accept_o(issue_accept), .issue_stall_o(issue_stall),
        .issue_lsu_o(i_lsu), .issue_csr_o(i_csr), .issue_div_o(i_div),
        .issue_mul_o(i_mul), .issue_branch_o(i_br), .issue_rd_valid_o(i_rdv),
        .issue_rd_o(issue_rd), .issue_exception_o(issue_exc),
        .take_interrupt_o(take_int),
        .issue_pc_o(issue_pc), .issue_opcode_o(issue_op),
        .issue_operand_ra_o(op_ra), .issue_operand_rb_o(op_rb)
    );

    biriscv_issue_ctrl #(.SUPPORT_LOAD_BYPASS(0)) dut_nolb (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_valid_i(fetch_valid), .fetch_accept_o(n_fetch_accept),
        .fetch_pc_i(fetch_pc), .fetch_instr_i(fetch_instr),
        .fetch_lsu_i(f_lsu), .fetch_csr_i(f_csr), .fetch_div_i(f_div),
        .fetch_mul_i(f_mul), .fetch_branch_i(f_br), .fetch_rd_valid_i(f_rdv),
        .fetch_exception_i(fetch_exc),
        .rf_ra_value_i(rf_ra), .rf_rb_value_i(rf_rb),
        .rd_e1_i(rd_e1), .rd_e2_i(rd_e2), .rd_wb_i(rd_wb),
        .alu_e1_i(alu_e1), .alu_result_e1_i(alu_res_e1),
        .load_e2_i(load_e2), .mul_e2_i(mul_e2),
        .result_e2_i(res_e2), .result_wb_i(res_wb),
        .pipe_stall_i(stall), .squash_i(squash), .redirect_i(redirect),
        .intr_pending_i(intr),
        .issue_valid_o(n_issue_valid), .issue_accept_o(n_issue_accept), .issue_stall_o(n_issue_stall),
        .issue_lsu_o(n_lsu), .issue_csr_o(n_csr), .issue_div_o(n_div),
        .issue_mul_o(n_mul), .issue_branch_o(n_br), .issue_rd_valid_o(n_rdv),
        .issue_rd_o(n_issue_rd), .issue_exception_o(n_issue_exc),
        .take_interrupt_o(n_take_int),
        .issue_pc_o(n_issue_pc), .issue_opcode_o(n_issue_op),
        .issue_operand_ra_o(n_op_ra), .issue_operand_rb_o(n_op_rb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        return {7'h00, rs2, rs1, 3'h0, rd, 7'h33};
    endfunction

    task automatic clear_inputs();
        fetch_valid = 0; fetch_pc = 32'h0; fetch_instr = 32'h0;
        f_lsu = 0; f_csr = 0; f_div = 0; f_mul = 0; f_br = 0; f_rdv = 0;
        fetch_exc = 6'h0;
        rf_ra = 32'h1111; rf_rb = 32'h2222;
        rd_e1 = 0; rd_e2 = 0; rd_wb = 0;
        alu_e1 = 0; load_e2 = 0; mul_e2 = 0;
        alu_res_e1 = 32'h1234; res_e2 = 32'hCAFE; res_wb = 32'hBEEF;
        stall = 0; squash = 0; redirect = 0; intr = 0;
    endtask

    task automatic flush();
        clear_inputs();
        squash = 1;
        tick();
        squash = 0;
    endtask

    task automatic load_slot(input logic [31:0] instr, input logic csr, input logic [5:0] exc);
        fetch_valid = 1; fetch_instr = instr; fetch_pc = 32'h8000_0000 + instr;
        f_csr = csr; fetch_exc = exc;
        tick();
        fetch_valid = 0; f_csr = 0; fetch_exc = 6'h0;
    endtask

    // Load a CSR instruction, let it fire and put a plain ADD behind it
    task automatic csr_then_add();
        load_slot(mk(0, 0, 1), 1'b1, 6'h0);
        fetch_valid = 1; fetch_instr = mk(0, 0, 2);
        tick();
        fetch_valid = 0;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [4:0]  e1, e2, wb;
        logic        alu, ld, ml, irq;
        logic [5:0]  exc;
        logic        exp_acc, exp_int;
        logic [31:0] exp_ra, exp_rb;
    } vec_t;

    vec_t vt[10];

    // Reference model: slot as a 0/1-entry queue plus a count of blocked cycles
    typedef struct {
        logic [31:0] pc, instr;
        logic        lsu, csr, div, mul, br, rdv;
        logic [5:0]  exc;
    } slot_t;

    slot_t mq[$];
    int    mblock;

    function automatic logic [31:0] ref_val(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'h0;
        if (idx == rd_e1) return alu_res_e1;
        if (idx == rd_e2) return res_e2;
        if (idx == rd_wb) return res_wb;
        return rf;
    endfunction

    // Only the E1 non-ALU producer is unbypassable with both bypass options built in
    function automatic bit ref_haz(input logic [4:0] idx);
        return (idx != 0) && (idx == rd_e1) && !alu_e1;
    endfunction

    task automatic model_cycle();
        bit    v, ign, blk, acc, fire, fa;
        slot_t s;
        slot_t n;
        v = (mq.size() != 0);
        if (v) s = mq[0];
        ign  = v && (intr || s.exc != 0);
        blk  = v && ((ref_haz(s.instr[19:15]) || ref_haz(s.instr[24:20])) && !ign);
        blk  = blk || (mblock != 0);
        acc  = v && !blk;
        fire = acc && !stall && !squash && !redirect;
        fa   = !redirect && !squash && (!v || fire);
        chk("rnd_valid", issue_valid, v);
        chk("rnd_accept", issue_accept, acc);
        chk("rnd_fetch_accept", fetch_accept, fa);
        chk("rnd_stall", issue_stall, stall);
        chk("rnd_take_int", take_int, intr && v && mblock == 0);
        if (v) begin
            chk("rnd_pc", issue_pc, s.pc);
            chk("rnd_opcode", issue_op, s.instr);
            chk("rnd_rd", issue_rd, s.instr[11:7]);
            chk("rnd_exc", issue_exc, s.exc);
            chk("rnd_class", {i_lsu, i_csr, i_div, i_mul, i_br, i_rdv},
                {s.lsu, s.csr, s.div, s.mul, s.br, s.rdv});
            chk("rnd_ra", op_ra, ref_val(s.instr[19:15], rf_ra));
            chk("rnd_rb", op_rb, ref_val(s.instr[24:20], rf_rb));
        end
        if (squash || redirect) begin
            mq.delete();
            mblock = 0;
        end else begin
            if (fire) void'(mq.pop_front());
            if (fire && s.csr) mblock = 3;
            else if (!stall && mblock > 0) mblock--;
            if (fetch_valid && fa) begin
                n = '{fetch_pc, fetch_instr, f_lsu, f_csr, f_div, f_mul, f_br, f_rdv, fetch_exc};
                mq.push_back(n);
            end
        end
    endtask

    task automatic rand_inputs();
        fetch_valid = ($urandom_range(3) != 0);
        fetch_pc    = $urandom;
        fetch_instr = {7'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                       3'($urandom), 5'($urandom), 7'($urandom)};
        {f_lsu, f_div, f_mul, f_br, f_rdv} = 5'($urandom);
        f_csr       = ($urandom_range(6) == 0);
        fetch_exc   = ($urandom_range(9) == 0) ? 6'($urandom_range(63, 1)) : 6'h0;
        rf_ra = $urandom; rf_rb = $urandom;
        rd_e1 = 5'($urandom_range(7)); rd_e2 = 5'($urandom_range(7)); rd_wb = 5'($urandom_range(7));
        alu_e1 = $urandom_range(1); load_e2 = $urandom_range(1); mul_e2 = $urandom_range(1);
        alu_res_e1 = $urandom; res_e2 = $urandom; res_wb = $urandom;
        stall    = ($urandom_range(3) == 0);
        squash   = ($urandom_range(19) == 0);
        redirect = ($urandom_range(19) == 0);
        intr     = ($urandom_range(6) == 0);
    endtask

    initial begin
        //        rs1 rs2 e1 e2 wb alu ld ml irq exc    acc int ra            rb
        vt[0] = '{5,  0,  5, 0, 0, 1,  0, 0, 0,  6'h00, 1,  0,  32'h1234, 32'h0};
        vt[1] = '{3,  4,  0, 0, 0, 0,  0, 0, 0,  6'h00, 1,  0,  32'h1111, 32'h2222};
        vt[2] = '{6,  6,  6, 0, 0, 0,  0, 0, 0,  6'h00, 0,  0,  32'h1234, 32'h1234};
        vt[3] = '{2,  3,  0, 2, 3, 0,  1, 0, 0,  6'h00, 1,  0,  32'hCAFE, 32'hBEEF};
        vt[4] = '{4,  4,  4, 4, 4, 1,  0, 0, 0,  6'h00, 1,  0,  32'h1234, 32'h1234};
        vt[5] = '{0,  0,  0, 0, 0, 0,  1, 1, 0,  6'h00, 1,  0,  32'h0,    32'h0};
        vt[6] = '{9,  7,  0, 7, 9, 0,  0, 1, 0,  6'h00, 1,  0,  32'hBEEF, 32'hCAFE};
        vt[7] = '{1,  2,  2, 0, 0, 0,  0, 0, 1,  6'h00, 1,  1,  32'h1111, 32'h1234};
        vt[8] = '{1,  2,  1, 0, 0, 0,  0, 0, 0,  6'h12, 1,  0,  32'h1234, 32'h2222};
        vt[9] = '{8,  8,  3, 8, 0, 0,  0, 0, 0,  6'h00, 1,  0,  32'hCAFE, 32'hCAFE};

        clear_inputs();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();

        // Reset values
        @(negedge clk);
        chk("rst_valid", issue_valid, 0);
        chk("rst_fetch_accept", fetch_accept, 1);
        chk("rst_opcode", issue_op, 0);
        tick();

        // Vector table: hazard and forwarding per operand
        for (int i = 0; i < 10; i++) begin
            flush();
            load_slot(mk(vt[i].rs1, vt[i].rs2, 5'd10), 1'b0, vt[i].exc);
            rd_e1 = vt[i].e1; rd_e2 = vt[i].e2; rd_wb = vt[i].wb;
            alu_e1 = vt[i].alu; load_e2 = vt[i].ld; mul_e2 = vt[i].ml; intr = vt[i].irq;
            @(negedge clk);
            chk($sformatf("vec%0d_accept", i), issue_accept, vt[i].exp_acc);
            chk($sformatf("vec%0d_take_int", i), take_int, vt[i].exp_int);
            chk($sformatf("vec%0d_ra", i), op_ra, vt[i].exp_ra);
            chk($sformatf("vec%0d_rb", i), op_rb, vt[i].exp_rb);
            tick();
        end

        // Load-use: one bubble with E2 load bypass, two without
        flush();
        load_slot(mk(0, 6, 10), 1'b0, 6'h0);
        rd_e1 = 6; alu_e1 = 0;
        @(negedge clk);
        chk("lu_e1_accept", issue_accept, 0);
        chk("lu_e1_accept_nolb", n_issue_accept, 0);
        tick();
        rd_e1 = 0; rd_e2 = 6; load_e2 = 1; res_e2 = 32'hCAFE;
        @(negedge clk);
        chk("lu_e2_accept", issue_accept, 1);
        chk("lu_e2_rb", op_rb, 32'hCAFE);
        chk("lu_e2_accept_nolb", n_issue_accept, 0);
        tick();
        rd_e2 = 0; load_e2 = 0; res_e2 = 32'h5555; rd_wb = 6; res_wb = 32'hCAFE;
        @(negedge clk);
        chk("lu_wb_valid", issue_valid, 0);
        chk("lu_wb_accept_nolb", n_issue_accept, 1);
        chk("lu_wb_rb_nolb", n_op_rb, 32'hCAFE);
        tick();

        // CSR drain: three unstalled blocked cycles
        flush();
        load_slot(mk(0, 0, 1), 1'b1, 6'h0);
        fetch_valid = 1; fetch_instr = mk(0, 0, 2);
        @(negedge clk);
        chk("csr_fire_accept", issue_accept, 1);
        chk("csr_fire_fetch_accept", fetch_accept, 1);
        tick();
        fetch_valid = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("csr_block%0d", c), issue_accept, 0);
            tick();
        end
        @(negedge clk);
        chk("csr_release", issue_accept, 1);
        tick();

        // CSR drain with a two-cycle stall inside it: five blocked cycles
        flush();
        csr_then_add();
        for (int c = 1; c <= 5; c++) begin
            stall = (c == 2 || c == 3);
            @(negedge clk);
            chk($sformatf("csrst_block%0d", c), issue_accept, 0);
            chk($sformatf("csrst_stall%0d", c), issue_stall, stall);
            tick();
        end
        stall = 0;
        @(negedge clk);
        chk("csrst_release", issue_accept, 1);
        tick();

        // Squash pulse with full slot and busy drain counter
        flush();
        csr_then_add();
        squash = 1; fetch_valid = 1; fetch_instr = mk(0, 0, 3);
        @(negedge clk);
        chk("sq_fetch_accept", fetch_accept, 0);
        chk("sq_valid_during", issue_valid, 1);
        tick();
        squash = 0; fetch_valid = 0;
        @(negedge clk);
        chk("sq_valid_after", issue_valid, 0);
        chk("sq_fetch_accept_after", fetch_accept, 1);
        tick();
        load_slot(mk(0, 0, 4), 1'b0, 6'h0);
        @(negedge clk);
        chk("sq_cnt_cleared", issue_accept, 1);
        tick();

        // Interrupt over a load-use hazard, then while CSR draining
        flush();
        load_slot(mk(7, 0, 1), 1'b0, 6'h0);
        rd_e1 = 7; alu_e1 = 0; intr = 1;
        @(negedge clk);
        chk("irq_take", take_int, 1);
        chk("irq_accept", issue_accept, 1);
        tick();
        @(negedge clk);
        chk("irq_consumed", issue_valid, 0);
        tick();
        flush();
        csr_then_add();
        intr = 1;
        @(negedge clk);
        chk("irq_csr_take", take_int, 0);
        chk("irq_csr_accept", issue_accept, 0);
        tick();

        // Asynchronous reset with slot full and drain counter at 2
        flush();
        csr_then_add();
        tick();
        intr = 1;
        #2 rst_n = 0;
        #1;
        chk("arst_valid", issue_valid, 0);
        chk("arst_accept", issue_accept, 0);
        chk("arst_take_int", take_int, 0);
        chk("arst_fetch_accept", fetch_accept, 1);
        chk("arst_pc", issue_pc, 0);
        chk("arst_opcode", issue_op, 0);
        chk("arst_ra", op_ra, 0);
        chk("arst_rb", op_rb, 0);
        chk("arst_rd_exc", {issue_rd, issue_exc}, 0);
        tick();
        rst_n = 1;
        intr = 0;
        tick();

        // Random traffic against the reference model
        flush();
        mq.delete();
        mblock = 0;
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            @(negedge clk);
            model_cycle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
